// File: rtl/axi_i2s_tx.sv
// AXI4-Stream to I2S master transmitter: one stereo sample per beat, one-entry
// holding buffer, silence plus a saturating counter on underrun.
module axi_i2s_tx #(
  parameter int BCLK_DIV_BITS = 3,
  parameter int UNDERRUN_W    = 16
) (
  input  logic                  mclk,
  input  logic                  mclk_rstn,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic [31:0]           s_axis_tdata,
  input  logic                  s_axis_tlast,
  output logic                  bclk,
  output logic                  lrclk,
  output logic                  sdo,
  output logic                  underrun,
  output logic [UNDERRUN_W-1:0] underrun_cnt
);

  localparam logic [BCLK_DIV_BITS-1:0] DIV_ONE = 1;
  localparam logic [UNDERRUN_W-1:0]    CNT_ONE = 1;

  logic [BCLK_DIV_BITS-1:0] div_cnt;
  logic [4:0]               slot_cnt;
  logic [4:0]               slot_next;
  logic [31:0]              shift;
  logic [31:0]              hold;
  logic                     hold_valid;
  logic                     started;
  logic                     fall_tick;
  logic                     frame_load;
  logic                     accept;
  logic                     tlast_unused;

  assign tlast_unused  = s_axis_tlast;
  assign fall_tick     = (div_cnt == '1);
  assign slot_next     = slot_cnt + 5'd1;
  assign frame_load    = fall_tick && (slot_cnt == 5'd31);
  assign s_axis_tready = ~hold_valid & mclk_rstn;
  assign accept        = s_axis_tvalid & s_axis_tready;
  assign bclk          = div_cnt[BCLK_DIV_BITS-1];
  assign sdo           = shift[31];

  // lrclk and shift only move on the bclk falling edge so the receiver samples on rising.
  always_ff @(posedge mclk) begin
    if (!mclk_rstn) begin
      div_cnt      <= '0;
      slot_cnt     <= 5'd31;
      shift        <= '0;
      hold         <= '0;
      hold_valid   <= 1'b0;
      started      <= 1'b0;
      lrclk        <= 1'b0;
      underrun     <= 1'b0;
      underrun_cnt <= '0;
    end else begin
      div_cnt  <= div_cnt + DIV_ONE;
      underrun <= 1'b0;
      if (fall_tick) begin
        slot_cnt <= slot_next;
        lrclk    <= (slot_next >= 5'd15) && (slot_next <= 5'd30);
        if (frame_load) begin
          shift <= hold_valid ? hold : 32'd0;
        end else begin
          shift <= {shift[30:0], 1'b0};
        end
      end
      if (frame_load) begin
        hold_valid <= 1'b0;
        if (!hold_valid && started) begin
          underrun <= 1'b1;
          if (underrun_cnt != '1) begin
            underrun_cnt <= underrun_cnt + CNT_ONE;
          end
        end
      end
      // An accept can only happen with the buffer empty, so it never races the load's clear.
      if (accept) begin
        hold       <= s_axis_tdata;
        hold_valid <= 1'b1;
        started    <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_axi_i2s_tx.sv
// Randomised and directed bench for axi_i2s_tx; expected waveforms come from a
// frame-level model that derives slot and bit positions from the edge count.
module tb_axi_i2s_tx;

  localparam int UW      = 2;
  localparam int CNT_MAX = (1 << UW) - 1;

  logic          mclk;
  logic          mclk_rstn;
  logic          s_axis_tvalid;
  logic          s_axis_tready;
  logic [31:0]   s_axis_tdata;
  logic          s_axis_tlast;
  logic          bclk;
  logic          lrclk;
  logic          sdo;
  logic          underrun;
  logic [UW-1:0] underrun_cnt;

  axi_i2s_tx #(.BCLK_DIV_BITS(3), .UNDERRUN_W(UW)) dut (
    .mclk          (mclk),
    .mclk_rstn     (mclk_rstn),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tlast  (s_axis_tlast),
    .bclk          (bclk),
    .lrclk         (lrclk),
    .sdo           (sdo),
    .underrun      (underrun),
    .underrun_cnt  (underrun_cnt)
  );

  initial mclk = 1'b0;
  always #5 mclk = ~mclk;

  int checks = 0;
  int errors = 0;

  // Reference state: edges since release, the word on air, one buffered beat.
  int          m_n;
  logic        m_hold_valid;
  logic [31:0] m_hold;
  logic        m_started;
  logic [31:0] m_frame;
  int          m_cnt;
  logic        m_underrun;
  logic        m_accepted;
  int          m_underrun_total;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s at n=%0d observed %0h expected %0h", tag, m_n, obs, exp);
    end
  endtask

  task automatic modelEdge();
    if (!mclk_rstn) begin
      m_n          = 0;
      m_hold_valid = 1'b0;
      m_hold       = '0;
      m_started    = 1'b0;
      m_frame      = '0;
      m_cnt        = 0;
      m_underrun   = 1'b0;
      m_accepted   = 1'b0;
    end else begin
      m_accepted = s_axis_tvalid && !m_hold_valid;
      m_n++;
      m_underrun = 1'b0;
      if (m_n >= 8 && ((m_n - 8) % 256) == 0) begin
        if (m_hold_valid) begin
          m_frame = m_hold;
        end else begin
          m_frame = '0;
          if (m_started) begin
            m_underrun = 1'b1;
            m_underrun_total++;
            if (m_cnt < CNT_MAX) m_cnt++;
          end
        end
        m_hold_valid = 1'b0;
      end
      if (m_accepted) begin
        m_hold       = s_axis_tdata;
        m_hold_valid = 1'b1;
        m_started    = 1'b1;
      end
    end
  endtask

  task automatic compareAll();
    int   slot;
    logic exp_lr;
    logic exp_sdo;
    if (m_n < 8) begin
      exp_lr  = 1'b0;
      exp_sdo = 1'b0;
    end else begin
      slot    = ((m_n - 8) / 8) % 32;
      exp_lr  = (slot >= 15) && (slot <= 30);
      exp_sdo = m_frame[31 - slot];
    end
    checkOutput("bclk",     {31'd0, bclk},          {31'd0, (m_n % 8) >= 4});
    checkOutput("lrclk",    {31'd0, lrclk},         {31'd0, exp_lr});
    checkOutput("sdo",      {31'd0, sdo},           {31'd0, exp_sdo});
    checkOutput("tready",   {31'd0, s_axis_tready}, {31'd0, mclk_rstn && !m_hold_valid});
    checkOutput("underrun", {31'd0, underrun},      {31'd0, m_underrun});
    checkOutput("urun_cnt", 32'(underrun_cnt),      32'(m_cnt));
  endtask

  task automatic applyStimulus(input logic valid, input logic [31:0] data, input logic rstn);
    s_axis_tvalid = valid;
    s_axis_tdata  = data;
    s_axis_tlast  = 1'($urandom_range(0, 1));
    mclk_rstn     = rstn;
    @(posedge mclk);
    modelEdge();
    #1;
    compareAll();
  endtask

  task automatic doReset();
    applyStimulus(1'b0, 32'd0, 1'b0);
    applyStimulus(1'b0, 32'd0, 1'b0);
  endtask

  task automatic idleUntil(input int target);
    while (m_n < target) applyStimulus(1'b0, 32'd0, 1'b1);
  endtask

  task automatic sendBeat(input logic [31:0] data);
    int guard;
    guard = 0;
    do begin
      applyStimulus(1'b1, data, 1'b1);
      guard++;
    end while (!m_accepted && guard < 600);
    checkOutput("beat_accepted", {31'd0, m_accepted}, 32'd1);
  endtask

  logic [31:0] stream [3];
  int          idx;
  int          urun_before;
  logic        pend;
  logic [31:0] pend_data;

  initial begin
    m_underrun_total = 0;
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tlast  = 1'b0;
    mclk_rstn     = 1'b0;

    $display("[TB] single sample, starvation and saturation");
    doReset();
    applyStimulus(1'b1, 32'hA5A5_3C3C, 1'b1);
    checkOutput("first_accept", {31'd0, m_accepted}, 32'd1);
    urun_before = m_underrun_total;
    idleUntil(8 + 256 * 6 - 1);
    checkOutput("urun_pulses", 32'(m_underrun_total - urun_before), 32'd5);
    checkOutput("urun_sat", 32'(underrun_cnt), 32'(CNT_MAX));

    $display("[TB] beat accepted on a load edge");
    applyStimulus(1'b1, 32'h1234_ABCD, 1'b1);
    checkOutput("load_edge_accept", {31'd0, m_accepted}, 32'd1);
    idleUntil(8 + 256 * 8 + 4);

    $display("[TB] back-to-back stream");
    stream[0] = 32'h0001_8000;
    stream[1] = 32'h7FFF_FFFF;
    stream[2] = 32'h8000_0001;
    doReset();
    idx = 0;
    urun_before = m_underrun_total;
    while (idx < 3 && m_n < 2000) begin
      applyStimulus(1'b1, stream[idx], 1'b1);
      if (m_accepted) idx++;
    end
    checkOutput("stream_all_accepted", 32'(idx), 32'd3);
    idleUntil(8 + 256 * 3 - 1);
    checkOutput("stream_no_underrun", 32'(m_underrun_total - urun_before), 32'd0);
    idleUntil(8 + 256 * 3 + 20);

    $display("[TB] idle after reset");
    doReset();
    idleUntil(8 + 256 * 5 + 4);
    checkOutput("idle_cnt", 32'(underrun_cnt), 32'd0);

    $display("[TB] mid-frame reset");
    doReset();
    applyStimulus(1'b1, 32'hDEAD_BEEF, 1'b1);
    idleUntil(19);
    sendBeat(32'hCAFE_F00D);
    idleUntil(88);
    checkOutput("hold_full_before_reset", {31'd0, s_axis_tready}, 32'd0);
    applyStimulus(1'b0, 32'd0, 1'b0);
    idleUntil(8 + 256 * 2 + 4);

    $display("[TB] randomized traffic");
    doReset();
    pend = 1'b0;
    pend_data = '0;
    while (m_n < 8 + 256 * 10) begin
      if (!pend && $urandom_range(0, 149) == 0) begin
        pend      = 1'b1;
        pend_data = $urandom;
      end
      applyStimulus(pend, pend_data, 1'b1);
      if (m_accepted) pend = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
